seq_restoring_divider: RTL
==========================

Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned restoring divider: the inverse operation of the team's combinational multiplier.
- Computes one quotient bit per clock.
- A product of two WIDTH/2-bit operands fed back with one factor as divisor returns the other factor, remainder 0.
- Sits beside the multiplier in the arithmetic lab set; driven by a start/done handshake from a controller or testbench.

Parameters:
- WIDTH, 4, bit width of dividend, divisor, quotient and remainder (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator, captured on accepted start
- divisor  input  WIDTH  denominator, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse: result valid
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered flag for the last result

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; busy, done, quotient, remainder, div_by_zero all 0; step counter 0.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge is accepted; dividend and divisor are latched.
  - divisor!=0: working quotient=dividend, working remainder=0 (WIDTH+1 bits), counter=WIDTH, next=RUN.
  - divisor==0: next=DONE with quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1.
- RUN: one step per edge.
  - Shift {rem,quo} left by 1.
  - trial = rem - divisor (WIDTH+1 bits).
  - If trial MSB==0: rem=trial and quo[0]=1; else keep rem and set quo[0]=0.
  - Counter decrements. On the edge performing the final step, next=DONE and quotient/remainder outputs load, with div_by_zero=0.
- DONE: lasts exactly one cycle, then IDLE. done=1 only in this state; busy=1 only in RUN.
- Latency:
  - Normal divide: done high in the cycle after edge WIDTH, counting the accepting edge as edge 0.
  - Divide-by-zero: done high in the cycle after edge 0.
- Outputs quotient/remainder/div_by_zero hold their values until the next result loads.
- start while busy or in DONE is ignored; no queueing.
- start held high continuously starts a new divide each time IDLE is re-entered.
- Invariant for every non-zero divisor: dividend == quotient*divisor + remainder, and remainder < divisor.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - At accept, latch the absolute values plus the sign bits.
  - Run the unsigned core unchanged.
  - On entry to DONE, negate the quotient if the signs differ; give the remainder the dividend's sign.
  - Quotient truncates toward zero.
  - Most-negative / -1 yields quotient = most-negative (wrap), remainder 0.
  - Divide-by-zero: quotient = all ones (-1), remainder = dividend.
  - Latency is identical to unsigned mode.
- Undefined: purely unsigned as above.

Decomposition:
- Package seq_divider_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam for the counter width, clog2(WIDTH+1);
  - the divide-by-zero quotient constant.
- Natural sub-module: div_restore_step, purely combinational. Takes rem, quo, divisor; returns next rem, next quo. The FSM instantiates it once.

Test Plan (WIDTH=4 unless noted):
- 13/3: start pulse → busy for 4 cycles, done pulse once, quotient=4, remainder=1, div_by_zero=0.
- Exhaustive 0..15 by 1..15 loop → every result satisfies q*d+r==n with r<d; 9/3 → q=3, r=0 (multiplier inverse).
- 9/0 → done in the cycle after accept, quotient=15, remainder=9, div_by_zero=1. A following 8/2 → q=4, r=0, div_by_zero cleared.
- 15/4 started, then start re-asserted with 6/2 during busy → result q=3, r=3; the second request is ignored.
- 14/3 started, rst high at step 2 → no done; all outputs 0; a new 7/7 afterwards → q=1, r=0.
- SEQ_DIVIDER_SIGNED_EN: -7/2 → q=4'b1101 (-3), r=4'b1111 (-1); -8/-1 → q=4'b1000, r=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// ============================================================================
// Module      : seq_divider_pkg
// Description : Shared state encoding and constants for the restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned c_MAX_WIDTH = 16;
    localparam int unsigned c_CNT_W_MAX = $clog2(c_MAX_WIDTH + 1);

    // Quotient reported for a zero divisor; sliced down to the instance width.
    localparam logic [c_MAX_WIDTH-1:0] c_DBZ_QUOTIENT = '1;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_restore_step.sv
// ============================================================================
// Module      : div_restore_step
// Description : One combinational restoring-division step (shift, trial
//               subtract, restore or commit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_restore_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH-1:0] w_shift_quo;
    logic [WIDTH:0]   w_trial;
    logic             w_unused_rem_msb;

    // The partial remainder is always below the divisor, so its top bit is
    // zero and drops out of the shift.
    assign w_unused_rem_msb = i_rem[WIDTH];
    assign w_shift_rem      = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
    assign w_shift_quo      = {i_quo[WIDTH-2:0], 1'b0};
    assign w_trial          = w_shift_rem - {1'b0, i_divisor};

    always_comb begin
        o_rem = w_shift_rem;
        o_quo = w_shift_quo;
        if (!w_trial[WIDTH]) begin
            o_rem = w_trial;
            o_quo = {w_shift_quo[WIDTH-1:1], 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module      : seq_restoring_divider
// Description : Multi-cycle restoring divider, one quotient bit per clock,
//               start/done handshake. SEQ_DIVIDER_SIGNED_EN selects
//               two's-complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned c_CNT_W = cnt_width(WIDTH);

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_div;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;
    logic                 r_dbz;

    logic [WIDTH:0]       w_rem_next;
    logic [WIDTH-1:0]     w_quo_next;
    logic                 w_accept;
    logic                 w_last_step;
    logic                 w_divisor_zero;
    logic [WIDTH-1:0]     w_dividend_mag;
    logic [WIDTH-1:0]     w_divisor_mag;
    logic [WIDTH-1:0]     w_q_final;
    logic [WIDTH-1:0]     w_r_final;

    assign w_accept       = (r_state == IDLE) && start;
    assign w_last_step    = (r_state == RUN) && (r_cnt == c_CNT_W'(1));
    assign w_divisor_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // Magnitude of the most-negative value is representable unsigned.
    assign w_dividend_mag = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
    assign w_divisor_mag  = divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - divisor)  : divisor;
    assign w_q_final      = r_neg_q ? ({WIDTH{1'b0}} - w_quo_next) : w_quo_next;
    assign w_r_final      = r_neg_r ? ({WIDTH{1'b0}} - w_rem_next[WIDTH-1:0])
                                    : w_rem_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign w_dividend_mag = dividend;
    assign w_divisor_mag  = divisor;
    assign w_q_final      = w_quo_next;
    assign w_r_final      = w_rem_next[WIDTH-1:0];
`endif

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = w_divisor_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last_step) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_rem <= '0;
            r_quo <= w_dividend_mag;
            r_div <= w_divisor_mag;
            r_cnt <= c_CNT_W'(WIDTH);
            // A zero divisor skips the core and reports immediately.
            if (w_divisor_zero) begin
                r_quotient  <= c_DBZ_QUOTIENT[WIDTH-1:0];
                r_remainder <= dividend;
                r_dbz       <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (w_last_step) begin
                r_quotient  <= w_q_final;
                r_remainder <= w_r_final;
                r_dbz       <= 1'b0;
            end
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire
